a2d_spi_resp: RTL

A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

---
 rtl/a2d_pkg.sv | 10 +
 rtl/spi_sync_edge.sv | 20 ++
 rtl/a2d_spi_resp.sv | 99 +++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// a2d_pkg: shared A2D/SPI frame constants and responder state encoding
package a2d_pkg;
  localparam int FRAME_W_DEF = 16;
  localparam int NUM_CH_DEF  = 8;
  localparam int VAL_W       = 12;
  localparam int CH_MSB      = 13;
  localparam int CH_LSB      = 11;
  localparam int CH_W        = CH_MSB - CH_LSB + 1;
  typedef enum logic [1:0] {IDLE, FRONT, SHIFT} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchronizer plus history flop giving level and edge pulses
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);
  logic r_s1, r_s2, r_s3;
  // metastability chain, then the history flop that edges are measured against
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_s1, r_s2, r_s3} <= {3{RST_VAL}};
    else        {r_s1, r_s2, r_s3} <= {i_d, r_s1, r_s2};
  assign o_lvl  = r_s3;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;
endmodule

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI slave that captures a command frame and returns the previously selected channel
module a2d_spi_resp import a2d_pkg::*; #(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int NUM_CH  = NUM_CH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      SS_n,
  input  logic                      SCLK,
  input  logic                      MOSI,
  input  logic [VAL_W*NUM_CH-1:0]   ch_vals,
  output logic                      MISO,
  output logic                      cmd_vld,
  output logic [FRAME_W-1:0]        cmd
);
  localparam int CW = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_W);
  state_t               r_state, w_next;
  logic [FRAME_W-1:0]   r_tx_shft, r_rx_shft, r_cmd;
  logic [CW-1:0]        r_bit_cnt;
  logic [CH_W-1:0]      r_chan;
  logic                 r_cmd_vld;
  logic [VAL_W-1:0]     w_val;
  logic                 w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall, w_mosi;
  logic                 w_unused_ss_lvl, w_unused_sclk_lvl, w_unused_mosi_rise, w_unused_mosi_fall;
  logic                 w_load, w_rx_en, w_tx_en, w_done;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .i_d(SS_n),
    .o_lvl(w_unused_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(SCLK),
    .o_lvl(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .i_d(MOSI),
    .o_lvl(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  // channels beyond NUM_CH answer with zero
  assign w_val = (int'(r_chan) < NUM_CH) ? ch_vals[int'(r_chan)*VAL_W +: VAL_W] : '0;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  // next state; an SCLK fall coincident with selection counts as the front edge
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_next = w_sclk_fall ? SHIFT : FRONT;
      FRONT:   w_next = w_ss_rise ? IDLE : w_sclk_fall ? SHIFT : FRONT;
      SHIFT:   if (w_ss_rise) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // datapath strobes; shifting stops once a full frame of rises has been seen
  always_comb begin
    w_load  = (r_state == IDLE) && w_ss_fall;
    w_rx_en = (r_state == SHIFT) && w_sclk_rise && (r_bit_cnt != FULL);
    w_tx_en = (r_state == SHIFT) && w_sclk_fall && (r_bit_cnt != FULL);
    w_done  = (r_state == SHIFT) && w_ss_rise && (r_bit_cnt == FULL);
  end

  // shift registers, bit counter, and command/channel capture on a complete frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tx_shft <= '0;
      r_rx_shft <= '0;
      r_bit_cnt <= '0;
      r_cmd     <= '0;
      r_chan    <= '0;
      r_cmd_vld <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx_shft <= {{(FRAME_W-VAL_W){1'b0}}, w_val};
        r_rx_shft <= '0;
        r_bit_cnt <= '0;
      end else begin
        if (w_tx_en) r_tx_shft <= {r_tx_shft[FRAME_W-2:0], 1'b0};
        if (w_rx_en) begin
          r_rx_shft <= {r_rx_shft[FRAME_W-2:0], w_mosi};
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end
      if (w_done) begin
        r_cmd  <= r_rx_shft;
        r_chan <= r_rx_shft[CH_MSB:CH_LSB];
      end
      r_cmd_vld <= w_done;
    end

  assign MISO    = r_tx_shft[FRAME_W-1];
  assign cmd     = r_cmd;
  assign cmd_vld = r_cmd_vld;
endmodule
